// File: rtl/ramp_seq_mc.sv
// Multi-channel piecewise-linear ramp sequencer with a runtime-programmable segment table.
// Define RAMP_SEQ_LOOP_EN to add the `loop` input, which restarts the sequence at its end.
module ramp_seq_mc #(
  parameter int NCH  = 2,
  parameter int NSEG = 8,
  parameter int W    = 16,
  parameter int FRAC = 14,
  parameter int DW   = 24,
  parameter int TW   = 16,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int SW  = (NSEG > 1) ? $clog2(NSEG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      div,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [CW-1:0]    wr_ch,
  input  logic [SW-1:0]    wr_seg,
  input  logic [DW-1:0]    wr_data,
`ifdef RAMP_SEQ_LOOP_EN
  input  logic             loop,
`endif
  output logic [NCH*W-1:0] out,
  output logic             busy,
  output logic [SW-1:0]    seg,
  output logic             trig,
  output logic             done,
  output logic             wr_err
);

  localparam int AW  = W + FRAC;
  localparam int AW1 = AW + 1;
  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}, {FRAC{1'b0}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic signed [AW-1:0]  acc_q [NCH];
  logic signed [AW-1:0]  acc_d [NCH];
  logic [TW-1:0]         cnt_q, cnt_d;
  logic [15:0]           pre_q, pre_d;
  logic [SW-1:0]         seg_q, seg_d;
  logic                  trig_q, trig_d, done_q, done_d, wrErr_q, wrErr_d;

  logic [TW-1:0]         dur_q [NSEG];
  logic [NSEG-1:0]       last_q, trigFlag_q;
  logic signed [DW-1:0]  step_q [NCH][NSEG];
  logic signed [W-1:0]   init_q [NCH];

  logic loopReq, advance, doLoad, wrAccept, rangeBad;

`ifdef RAMP_SEQ_LOOP_EN
  assign loopReq = loop;
`else
  assign loopReq = 1'b0;
`endif

  function automatic logic signed [AW-1:0] satAdd(input logic signed [AW-1:0] a,
                                                  input logic signed [DW-1:0] s);
    logic signed [AW:0] sum;
    sum = AW1'(a) + AW1'(s);
    if (sum[AW] != sum[AW-1]) return sum[AW] ? ACC_MIN : ACC_MAX;
    return sum[AW-1:0];
  endfunction

  // Channel index matters for step/init writes, segment index for control/step writes.
  always_comb begin
    rangeBad = 1'b0;
    if ((wr_sel == 2'd1 || wr_sel == 2'd2) && int'(wr_ch) >= NCH) rangeBad = 1'b1;
    if ((wr_sel == 2'd0 || wr_sel == 2'd1) && int'(wr_seg) >= NSEG) rangeBad = 1'b1;
    wrAccept = wr_en && (state_q == IDLE) && !rangeBad && (wr_sel != 2'd3);
    wrErr_d  = wr_en && ((state_q != IDLE) || rangeBad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSEG; s++) dur_q[s] <= '0;
      last_q     <= '0;
      trigFlag_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        init_q[c] <= '0;
        for (int s = 0; s < NSEG; s++) step_q[c][s] <= '0;
      end
    end else if (wrAccept) begin
      case (wr_sel)
        2'd0: begin
          dur_q[wr_seg]      <= wr_data[TW-1:0];
          last_q[wr_seg]     <= wr_data[TW];
          trigFlag_q[wr_seg] <= wr_data[TW+1];
        end
        2'd1:    step_q[wr_ch][wr_seg] <= wr_data;
        2'd2:    init_q[wr_ch] <= wr_data[W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      seg_q   <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      wrErr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int c = 0; c < NCH; c++) acc_q[c] <= acc_d[c];
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      seg_q   <= seg_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
      wrErr_q <= wrErr_d;
    end
  end

  // A zero-duration segment holds the prescaler so following segments keep n*(div+1) timing.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    seg_d   = seg_q;
    trig_d  = 1'b0;
    done_d  = 1'b0;
    advance = 1'b0;
    doLoad  = 1'b0;
    case (state_q)
      IDLE: if (start && !abort) doLoad = 1'b1;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (cnt_q == '0) begin
            advance = 1'b1;
          end else if (pre_q == div) begin
            pre_d = '0;
            cnt_d = cnt_q - 1'b1;
            for (int c = 0; c < NCH; c++) acc_d[c] = satAdd(acc_q[c], step_q[c][seg_q]);
            if (cnt_q == TW'(1)) advance = 1'b1;
          end else begin
            pre_d = pre_q + 1'b1;
          end
          if (advance) begin
            if (last_q[seg_q] || seg_q == SW'(NSEG-1)) begin
              done_d = 1'b1;
              if (loopReq) doLoad = 1'b1;
              else         state_d = DONE;
            end else begin
              seg_d  = seg_q + 1'b1;
              cnt_d  = dur_q[seg_q + 1'b1];
              trig_d = trigFlag_q[seg_q + 1'b1];
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (doLoad) begin
      state_d = RUN;
      for (int c = 0; c < NCH; c++) acc_d[c] = {init_q[c], {FRAC{1'b0}}};
      seg_d  = '0;
      cnt_d  = dur_q[0];
      pre_d  = '0;
      trig_d = trigFlag_q[0];
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    out  = '0;
    for (int c = 0; c < NCH; c++) out[c*W +: W] = acc_q[c][AW-1:FRAC];
  end

  assign seg    = seg_q;
  assign trig   = trig_q;
  assign done   = done_q;
  assign wr_err = wrErr_q;

endmodule

// File: tb/tb_ramp_seq_mc.sv
// Self-checking bench for ramp_seq_mc: vector table, hand-written corner sequences and
// randomized tables checked against a cycle-timeline reference model.
module tb_ramp_seq_mc;
  localparam int NCH = 2, NSEG = 8, W = 16, FRAC = 14, DW = 28, TW = 16;
  localparam int CW = 1, SW = 3;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, wr_en = 1'b0;
  logic [15:0] div = '0;
  logic [1:0] wr_sel = '0;
  logic [CW-1:0] wr_ch = '0;
  logic [SW-1:0] wr_seg = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NCH*W-1:0] dutOut;
  logic busy, trig, done, wr_err;
  logic [SW-1:0] seg;
`ifdef RAMP_SEQ_LOOP_EN
  logic loop = 1'b0;
`endif

  ramp_seq_mc #(.NCH(NCH), .NSEG(NSEG), .W(W), .FRAC(FRAC), .DW(DW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .div(div),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_ch(wr_ch), .wr_seg(wr_seg), .wr_data(wr_data),
`ifdef RAMP_SEQ_LOOP_EN
    .loop(loop),
`endif
    .out(dutOut), .busy(busy), .seg(seg), .trig(trig), .done(done), .wr_err(wr_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Shadow copy of what the table should hold.
  int durT[NSEG];
  bit lastT[NSEG], trigT[NSEG];
  int stepT[NCH][NSEG];
  int initT[NCH];

  // Expected per-cycle timeline, index j = state right after edge E+j.
  bit expBusy[$], expDone[$], expTrig[$];
  int expSeg[$], expOut[$];

  typedef struct {
    bit startIn;
    int expOut0;
    bit expBusy;
    bit expDone;
  } vec_t;
  vec_t vecs[7];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int outCh(input int c);
    return int'($signed(dutOut[c*W +: W]));
  endfunction

  task automatic applyStimulus(input bit s, input bit a);
    start = s;
    abort = a;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1; start = 0; abort = 0; wr_en = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < NSEG; s++) begin
      durT[s] = 0; lastT[s] = 0; trigT[s] = 0;
      for (int c = 0; c < NCH; c++) stepT[c][s] = 0;
    end
    for (int c = 0; c < NCH; c++) initT[c] = 0;
  endtask

  task automatic writeTable(input int sel, input int ch, input int sg, input int data);
    wr_en = 1; wr_sel = 2'(sel); wr_ch = CW'(ch); wr_seg = SW'(sg); wr_data = DW'(data);
    @(posedge clk);
    #1 wr_en = 0;
    checkOutput("wr_err_accepted", int'(wr_err), 0);
    case (sel)
      0: begin durT[sg] = data & 16'hFFFF; lastT[sg] = data[TW]; trigT[sg] = data[TW+1]; end
      1: stepT[ch][sg] = data;
      2: initT[ch] = int'($signed(data[W-1:0]));
      default: ;
    endcase
  endtask

  task automatic writeCtrl(input int sg, input int dur, input bit lst, input bit tg);
    writeTable(0, 0, sg, (int'(tg) << (TW+1)) | (int'(lst) << TW) | dur);
  endtask

  task automatic pushRec(input bit b, input bit dn, input bit t, input int s, input longint a[NCH]);
    expBusy.push_back(b); expDone.push_back(dn); expTrig.push_back(t); expSeg.push_back(s);
    for (int c = 0; c < NCH; c++) expOut.push_back(int'(a[c] >>> FRAC));
  endtask

  // Expands the segment table into a cycle-by-cycle timeline: every step waits d idle
  // clocks then lands, zero segments take one clock, the sequence ends after the last one.
  task automatic buildTrace(input int d);
    longint acc[NCH];
    longint accMax, accMin;
    int s;
    bit fin;
    accMax = ((longint'(1) << (W-1)) - 1) << FRAC;
    accMin = -(longint'(1) << (W-1+FRAC));
    expBusy.delete(); expDone.delete(); expTrig.delete(); expSeg.delete(); expOut.delete();
    for (int c = 0; c < NCH; c++) acc[c] = longint'(initT[c]) * (longint'(1) << FRAC);
    s = 0;
    fin = 0;
    pushRec(1, 0, trigT[0], 0, acc);
    while (!fin) begin
      for (int k = 1; k <= durT[s]; k++) begin
        for (int h = 0; h < d; h++) pushRec(1, 0, 0, s, acc);
        for (int c = 0; c < NCH; c++) begin
          acc[c] = acc[c] + longint'(stepT[c][s]);
          if (acc[c] > accMax) acc[c] = accMax;
          if (acc[c] < accMin) acc[c] = accMin;
        end
        if (k < durT[s]) pushRec(1, 0, 0, s, acc);
      end
      if (lastT[s] || s == NSEG-1) begin
        pushRec(0, 1, 0, s, acc);
        pushRec(0, 0, 0, s, acc);
        fin = 1;
      end else begin
        s++;
        pushRec(1, 0, trigT[s], s, acc);
      end
    end
  endtask

  task automatic runTrace(input string name, input int d);
    buildTrace(d);
    div = 16'(d);
    for (int j = 0; j < expBusy.size(); j++) begin
      applyStimulus(j == 0, 0);
      checkOutput({name, "_busy"}, int'(busy), int'(expBusy[j]));
      checkOutput({name, "_done"}, int'(done), int'(expDone[j]));
      checkOutput({name, "_trig"}, int'(trig), int'(expTrig[j]));
      if (expBusy[j]) checkOutput({name, "_seg"}, int'(seg), expSeg[j]);
      for (int c = 0; c < NCH; c++) checkOutput({name, "_out"}, outCh(c), expOut[j*NCH + c]);
    end
    start = 0;
  endtask

  task automatic setupSingleRamp();
    writeTable(2, 0, 0, 1000);
    writeTable(1, 0, 0, 16384);
    writeCtrl(0, 4, 1, 0);
    div = 0;
  endtask

  initial begin
    vecs[0] = '{1, 1000, 1, 0};
    vecs[1] = '{0, 1001, 1, 0};
    vecs[2] = '{0, 1002, 1, 0};
    vecs[3] = '{0, 1003, 1, 0};
    vecs[4] = '{0, 1004, 0, 1};
    vecs[5] = '{0, 1004, 0, 0};
    vecs[6] = '{0, 1004, 0, 0};

    resetDut();
    $display("[TB] reset state");
    checkOutput("reset_out0", outCh(0), 0);
    checkOutput("reset_out1", outCh(1), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_trig", int'(trig), 0);
    checkOutput("reset_seg", int'(seg), 0);
    checkOutput("reset_wr_err", int'(wr_err), 0);

    $display("[TB] empty table");
    runTrace("empty", 0);

    $display("[TB] single-segment ramp vectors");
    setupSingleRamp();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].startIn, 0);
      checkOutput("vec_out0", outCh(0), vecs[i].expOut0);
      checkOutput("vec_busy", int'(busy), int'(vecs[i].expBusy));
      checkOutput("vec_done", int'(done), int'(vecs[i].expDone));
    end

    $display("[TB] saturation");
    resetDut();
    writeTable(2, 0, 0, 32000);
    writeTable(2, 1, 0, -32000);
    writeTable(1, 0, 0, 1000 * 16384);
    writeTable(1, 1, 0, -1000 * 16384);
    writeCtrl(0, 3, 1, 0);
    runTrace("sat", 2);
    checkOutput("sat_final_pos", outCh(0), 32767);
    checkOutput("sat_final_neg", outCh(1), -32768);

    $display("[TB] multi-segment with triggers");
    resetDut();
    writeCtrl(0, 2, 0, 1);
    writeTable(1, 0, 0, 16384);
    writeTable(1, 1, 0, -16384);
    writeCtrl(1, 0, 0, 0);
    writeCtrl(2, 1, 1, 1);
    writeTable(1, 0, 2, 5 * 16384);
    runTrace("multi", 0);
    checkOutput("multi_final0", outCh(0), 7);
    checkOutput("multi_final1", outCh(1), -2);

    $display("[TB] abort with rejected write");
    resetDut();
    setupSingleRamp();
    applyStimulus(1, 0);
    checkOutput("abort_e0", outCh(0), 1000);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("abort_e2", outCh(0), 1002);
    wr_en = 1; wr_sel = 2'd2; wr_ch = 0; wr_data = DW'(5);
    applyStimulus(0, 1);
    wr_en = 0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_wr_err", int'(wr_err), 1);
    checkOutput("abort_out_frozen", outCh(0), 1002);
    checkOutput("abort_no_done", int'(done), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0);
      checkOutput("abort_idle_done", int'(done), 0);
      checkOutput("abort_idle_out", outCh(0), 1002);
      checkOutput("abort_wr_err_clear", int'(wr_err), 0);
    end
    applyStimulus(1, 1);
    checkOutput("start_abort_busy", int'(busy), 0);
    checkOutput("start_abort_out", outCh(0), 1002);
    applyStimulus(1, 0);
    checkOutput("rejected_init_kept", outCh(0), 1000);
    applyStimulus(0, 1);
    checkOutput("abort2_busy", int'(busy), 0);

`ifdef RAMP_SEQ_LOOP_EN
    $display("[TB] loop mode");
    resetDut();
    setupSingleRamp();
    loop = 1;
    applyStimulus(1, 0);
    start = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 3; k++) begin
        applyStimulus(0, 0);
        checkOutput("loop_out", outCh(0), 1000 + k);
      end
      applyStimulus(0, 0);
      checkOutput("loop_reload_out", outCh(0), 1000);
      checkOutput("loop_done", int'(done), 1);
      checkOutput("loop_busy", int'(busy), 1);
    end
    applyStimulus(0, 1);
    loop = 0;
    checkOutput("loop_abort_busy", int'(busy), 0);
`endif

    $display("[TB] randomized tables");
    for (int it = 0; it < 8; it++) begin
      int d;
      resetDut();
      d = int'($urandom_range(0, 3));
      for (int c = 0; c < NCH; c++) writeTable(2, c, 0, int'($urandom_range(0, 65535)) - 32768);
      for (int s = 0; s < NSEG; s++) begin
        writeCtrl(s, int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
        for (int c = 0; c < NCH; c++) begin
          int r;
          r = ($urandom_range(0, 3) == 0) ? (1 << 26) : (1 << 16);
          writeTable(1, c, s, int'($urandom_range(0, 2 * r)) - r);
        end
      end
      runTrace("rand", d);
      repeat (2) applyStimulus(0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
